// File: rtl/ffs_sched_pkg.sv
// ffs_sched_pkg: shared state, tag type and default sizes for the FFS scheduler
package ffs_sched_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF = 1024;
  localparam int RES_W_DEF = 10;
  localparam int PIPE_LAT_DEF = 10;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_t;
  typedef logic [$clog2(NUM_REQ_DEF)-1:0] tag_t;
endpackage

// File: rtl/ffs_sched_rr_arb.sv
// ffs_sched_rr_arb: combinational round-robin grant, search starts at ptr and wraps
module ffs_sched_rr_arb #(
  parameter int NUM_REQ = 4,
  localparam int TAG_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   ptr,
  input  logic               grant_en,
  output logic [NUM_REQ-1:0] grant,
  output logic [TAG_W-1:0]   gidx,
  output logic               gvalid
);
  int j;
  // walk offsets from farthest to nearest so the nearest valid request wins
  always_comb begin
    grant = '0;
    gidx = '0;
    gvalid = 1'b0;
    j = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (grant_en && req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        gidx = TAG_W'(j);
        gvalid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ffs_scheduler.sv
// ffs_scheduler: round-robin sharing of a pipelined FFS unit; FFS_SCHED_CHECK_EN adds the sticky err checker
module ffs_scheduler
  import ffs_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W = RES_W_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [RES_W-1:0]          rsp_result,
  output logic                      busy,
  output logic                      ffs_in_valid,
  output logic [DATA_W-1:0]         ffs_in,
  input  logic [RES_W-1:0]          ffs_result,
`ifdef FFS_SCHED_CHECK_EN
  output logic                      err,
`endif
  input  logic                      ffs_out_valid
);
  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int DEPTH = PIPE_LAT + 2;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  sched_state_t state;
  logic [TAG_W-1:0] ptr, gidx;
  logic gvalid, grant_en, push, pop;
  logic [TAG_W-1:0] tags [DEPTH];
  logic [PW-1:0] wr, rd;
  logic [CW-1:0] cnt, cnt_nxt;
  assign grant_en = !reset && state == RUN && enable && cnt != CW'(DEPTH);
  ffs_sched_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .grant_en(grant_en),
    .grant(req_ready),
    .gidx(gidx),
    .gvalid(gvalid)
  );
  assign push = gvalid;
  // results with no owner are dropped rather than popping an empty FIFO
  assign pop = ffs_out_valid && cnt != '0;
  assign cnt_nxt = cnt + CW'(push) - CW'(pop);
  always_ff @(posedge clk) if (push) tags[wr] <= gidx;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      ptr <= '0;
      wr <= '0;
      rd <= '0;
      cnt <= '0;
      rsp_valid <= '0;
      rsp_result <= '0;
      ffs_in_valid <= 1'b0;
      ffs_in <= '0;
    end else begin
      state <= enable ? RUN : cnt_nxt != '0 ? DRAIN : IDLE;
      busy <= enable || cnt_nxt != '0;
      cnt <= cnt_nxt;
      ffs_in_valid <= push;
      rsp_valid <= pop ? NUM_REQ'(1) << tags[rd] : '0;
      if (push) begin
        ffs_in <= req_data[int'(gidx)*DATA_W +: DATA_W];
        ptr <= gidx == TAG_W'(NUM_REQ - 1) ? '0 : gidx + 1'b1;
        wr <= wr == PW'(DEPTH - 1) ? '0 : wr + 1'b1;
      end
      if (pop) begin
        rsp_result <= ffs_result;
        rd <= rd == PW'(DEPTH - 1) ? '0 : rd + 1'b1;
      end
    end
  end
`ifdef FFS_SCHED_CHECK_EN
  localparam int AW = $clog2(PIPE_LAT + 3);
  logic [AW-1:0] age [DEPTH];
  logic [DEPTH-1:0] live;
  logic aged;
  always_comb begin
    aged = 1'b0;
    for (int i = 0; i < DEPTH; i++) aged = aged | (live[i] && age[i] > AW'(PIPE_LAT + 1));
  end
  // per-slot age saturates one past the limit so a lost result stays visible
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
      live <= '0;
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else begin
      err <= err | (ffs_out_valid && cnt == '0) | aged;
      for (int i = 0; i < DEPTH; i++) begin
        if (push && wr == PW'(i)) begin
          live[i] <= 1'b1;
          age[i] <= '0;
        end else if (pop && rd == PW'(i)) live[i] <= 1'b0;
        else if (live[i] && age[i] != AW'(PIPE_LAT + 2)) age[i] <= age[i] + 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_ffs_scheduler.sv
// tb_ffs_scheduler: directed checks of ffs_scheduler against a 10-stage FFS model
module tb_ffs_scheduler;
  localparam int NUM_REQ = 4;
  localparam int DATA_W = 1024;
  localparam int RES_W = 10;
  localparam int PIPE_LAT = 10;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [NUM_REQ-1:0] req_valid = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0] req_ready, rsp_valid;
  logic [RES_W-1:0] rsp_result, ffs_result;
  logic busy, ffs_in_valid, ffs_out_valid;
  logic [DATA_W-1:0] ffs_in;
  logic inject = 1'b0;
`ifdef FFS_SCHED_CHECK_EN
  logic err;
`endif
  int checks = 0;
  int passes = 0;
  bit pv [PIPE_LAT];
  bit [RES_W-1:0] pr [PIPE_LAT];

  always #5 clk = ~clk;

  ffs_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .RES_W(RES_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_result(rsp_result),
    .busy(busy),
    .ffs_in_valid(ffs_in_valid),
    .ffs_in(ffs_in),
    .ffs_result(ffs_result),
`ifdef FFS_SCHED_CHECK_EN
    .err(err),
`endif
    .ffs_out_valid(ffs_out_valid)
  );

  function automatic logic [RES_W-1:0] ffs_ref(input logic [DATA_W-1:0] v);
    ffs_ref = '0;
    for (int i = DATA_W - 1; i >= 0; i--) if (v[i]) ffs_ref = RES_W'(i);
  endfunction

  // free-running FFS pipeline, deliberately not reset
  always @(posedge clk) begin
    pv[0] <= ffs_in_valid;
    pr[0] <= ffs_ref(ffs_in);
    for (int i = 1; i < PIPE_LAT; i++) begin
      pv[i] <= pv[i-1];
      pr[i] <= pr[i-1];
    end
  end
  assign ffs_out_valid = pv[PIPE_LAT-1] | inject;
  assign ffs_result = inject ? RES_W'(7) : pr[PIPE_LAT-1];

  task automatic pulse_reset;
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b0;
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    enable = 1'b1;
    req_valid = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0) $display("FAIL reset_req_ready got %b exp 0000", req_ready); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passes++;
    checks++; if (rsp_valid !== 4'b0) $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); else passes++;
    checks++; if (rsp_result !== 10'd0) $display("FAIL reset_rsp_result got %0d exp 0", rsp_result); else passes++;
    checks++; if (ffs_in_valid !== 1'b0) $display("FAIL reset_ffs_in_valid got %b exp 0", ffs_in_valid); else passes++;
    checks++; if (ffs_in !== '0) $display("FAIL reset_ffs_in got nonzero exp 0"); else passes++;
`ifdef FFS_SCHED_CHECK_EN
    checks++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else passes++;
`endif
    reset = 1'b0;
    enable = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single;
    int lat;
    @(negedge clk);
    enable = 1'b1;
    req_data = '0;
    req_data[2*DATA_W +: DATA_W] = DATA_W'(8'hF0);
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) $display("FAIL single_grant got %b exp 0100", req_ready); else passes++;
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (ffs_in_valid !== 1'b1) $display("FAIL single_in_valid got %b exp 1", ffs_in_valid); else passes++;
    checks++; if (ffs_in !== DATA_W'(8'hF0)) $display("FAIL single_ffs_in got %h exp f0", ffs_in[15:0]); else passes++;
    lat = 1;
    while (rsp_valid == '0 && lat < 30) begin
      @(negedge clk);
      #1;
      lat++;
    end
    checks++; if (lat !== 12) $display("FAIL single_latency got %0d exp 12", lat); else passes++;
    checks++; if (rsp_valid !== 4'b0100) $display("FAIL single_rsp_valid got %b exp 0100", rsp_valid); else passes++;
    checks++; if (rsp_result !== 10'd4) $display("FAIL single_rsp_result got %0d exp 4", rsp_result); else passes++;
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 4'b0) $display("FAIL single_strobe_width got %b exp 0000", rsp_valid); else passes++;
  endtask

  task automatic test_fairness;
    int w;
    pulse_reset();
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = DATA_W'(1) << (3*i + 1);
    @(negedge clk);
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (req_ready !== 4'(1 << (k % 4))) $display("FAIL fair_grant%0d got %b exp %b", k, req_ready, 4'(1 << (k % 4))); else passes++;
      @(negedge clk);
    end
    req_valid = '0;
    #1;
    w = 0;
    while (rsp_valid == '0 && w < 30) begin
      @(negedge clk);
      #1;
      w++;
    end
    for (int k = 0; k < 8; k++) begin
      checks++; if (rsp_valid !== 4'(1 << (k % 4))) $display("FAIL fair_rsp%0d got %b exp %b", k, rsp_valid, 4'(1 << (k % 4))); else passes++;
      checks++; if (rsp_result !== RES_W'(3*(k % 4) + 1)) $display("FAIL fair_res%0d got %0d exp %0d", k, rsp_result, 3*(k % 4) + 1); else passes++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_drain;
    int resp, bad, early;
    @(negedge clk);
    req_valid = 4'hF;
    repeat (5) @(negedge clk);
    enable = 1'b0;
    resp = 0;
    bad = 0;
    early = 0;
    repeat (40) begin
      #1;
      if (req_ready != '0) bad++;
      if (rsp_valid != '0) resp++;
      if (resp < 5 && busy !== 1'b1) early++;
      if (resp == 5) break;
      @(negedge clk);
    end
    @(negedge clk);
    #1;
    req_valid = '0;
    checks++; if (resp !== 5) $display("FAIL drain_responses got %0d exp 5", resp); else passes++;
    checks++; if (bad !== 0) $display("FAIL drain_grants got %0d exp 0", bad); else passes++;
    checks++; if (early !== 0) $display("FAIL drain_busy_early got %0d exp 0", early); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL drain_idle_busy got %b exp 0", busy); else passes++;
  endtask

  task automatic test_reset_mid;
    int stray;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    req_valid = 4'hF;
    repeat (3) @(negedge clk);
    req_valid = '0;
    enable = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL mid_busy got %b exp 0", busy); else passes++;
`ifdef FFS_SCHED_CHECK_EN
    checks++; if (err !== 1'b0) $display("FAIL mid_err_cleared got %b exp 0", err); else passes++;
`endif
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (rsp_valid != '0) stray++;
    end
    checks++; if (stray !== 0) $display("FAIL mid_stray_rsp got %0d exp 0", stray); else passes++;
`ifdef FFS_SCHED_CHECK_EN
    checks++; if (err !== 1'b1) $display("FAIL mid_err got %b exp 1", err); else passes++;
`endif
  endtask

  task automatic test_checker;
    int stray, low;
    pulse_reset();
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    stray = 0;
    low = 0;
    repeat (5) begin
      #1;
      if (rsp_valid != '0) stray++;
`ifdef FFS_SCHED_CHECK_EN
      if (err !== 1'b1) low++;
`endif
      @(negedge clk);
    end
    checks++; if (stray !== 0) $display("FAIL chk_stray_rsp got %0d exp 0", stray); else passes++;
`ifdef FFS_SCHED_CHECK_EN
    checks++; if (low !== 0) $display("FAIL chk_err_sticky got %0d low cycles exp 0", low); else passes++;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_drain();
    test_reset_mid();
    test_checker();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
